// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 boot-time register sequencer: walks a {addr,value} ROM and issues one
// SCCB write per entry, honouring delay and end-of-table markers.
module ov7670_cfg_sequencer #(
  parameter int DEV_F       = 500_000,
  parameter int DELAY_MS    = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fStart,
  input  logic       i_fReady,
  output logic       o_fStart,
  output logic [7:0] o_Addr,
  output logic [7:0] o_Data,
  output logic       o_fBusy,
  output logic       o_fDone,
  output logic       o_fError,
  output logic [5:0] o_Index
);

  localparam int          DELAY_CYC = DEV_F / 1000 * DELAY_MS;
  localparam logic [23:0] DLY_LAST  = 24'(DELAY_CYC - 1);
  localparam logic [23:0] ACK_LAST  = 24'(ACK_TIMEOUT - 1);

  localparam logic [15:0] ENT_END   = 16'hFFFF;
  localparam logic [15:0] ENT_DELAY = 16'hF0F0;

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, DELAY, DONE, ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  index_q, index_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        start_q, start_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] entry;
  logic [5:0]  index_inc;

  always_comb begin
    case (index_q)
      6'd0:    entry = 16'h1280;
      6'd1:    entry = ENT_DELAY;
      6'd2:    entry = 16'h1204;
      6'd3:    entry = 16'h1101;
      6'd4:    entry = 16'h40D0;
      6'd5:    entry = 16'h8C00;
      default: entry = ENT_END;
    endcase
  end

  // Entry 63 is always an end marker, so saturating here cannot stall the walk.
  assign index_inc = (index_q == 6'd63) ? index_q : index_q + 6'd1;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    addr_d  = addr_q;
    data_d  = data_q;
    start_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (i_fStart) begin
          state_d = FETCH;
          index_d = 6'd0;
        end
      end
      FETCH: begin
        if (entry == ENT_END) begin
          state_d = DONE;
        end else if (entry == ENT_DELAY) begin
          state_d = DELAY;
          cnt_d   = 24'd0;
        end else begin
          addr_d  = entry[15:8];
          data_d  = entry[7:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (i_fReady) begin
          start_d = 1'b1;
          cnt_d   = 24'd0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Writer must drop ready to acknowledge; a writer that never does is an error.
        if (!i_fReady)               state_d = WAIT_DONE;
        else if (cnt_q == ACK_LAST)  state_d = ERROR;
        else                         cnt_d   = cnt_q + 24'd1;
      end
      WAIT_DONE: begin
        if (i_fReady) begin
          index_d = index_inc;
          state_d = FETCH;
        end
      end
      DELAY: begin
        if (cnt_q == DLY_LAST) begin
          index_d = index_inc;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      index_q <= 6'd0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      start_q <= 1'b0;
      cnt_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_fStart = start_q;
  assign o_Addr   = addr_q;
  assign o_Data   = data_q;
  assign o_Index  = index_q;
  assign o_fDone  = (state_q == DONE);
  assign o_fError = (state_q == ERROR);
  assign o_fBusy  = !(state_q == IDLE || state_q == DONE || state_q == ERROR);

endmodule
